// File: rtl/can_rx_frame.sv
// CAN 2.0A receive frame decoder: bit sampling, hard sync on SOF, destuffing,
// CRC15/form checks, ACK slot drive and hand-off of the decoded frame.
module can_rx_frame #(
  parameter int OVS_FACTOR   = 16,
  parameter int SAMPLE_POINT = 10,
  parameter int IDLE_BITS    = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_16x,
  input  logic        can_rx,
  input  logic        ack_en,
  output logic        can_tx_ack,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_err,
  output logic [2:0]  err_code,
  output logic        busy
);
  localparam int CW = $clog2(OVS_FACTOR);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [14:0] POLY = 15'h4599;

  localparam logic [3:0] S_WAIT = 4'd0,  S_IDLE = 4'd1,  S_SOF  = 4'd2,  S_ID   = 4'd3,
                         S_RTR  = 4'd4,  S_IDE  = 4'd5,  S_R0   = 4'd6,  S_DLC  = 4'd7,
                         S_DATA = 4'd8,  S_CRC  = 4'd9,  S_CDEL = 4'd10, S_ACK  = 4'd11,
                         S_ADEL = 4'd12, S_EOF  = 4'd13;

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [5:0]    bcnt_q, bcnt_d;
  logic [2:0]    run_q, run_d;
  logic          last_q, last_d;
  logic [14:0]   crc_q, crc_d, rcrc_q, rcrc_d;
  logic [10:0]   id_sh_q, id_sh_d, rx_id_q, rx_id_d;
  logic          rtr_sh_q, rtr_sh_d, rx_rtr_q, rx_rtr_d;
  logic [3:0]    dlc_sh_q, dlc_sh_d, rx_dlc_q, rx_dlc_d, len_q, len_d;
  logic [63:0]   data_sh_q, data_sh_d, rx_data_q, rx_data_d;
  logic          ack_ok_q, ack_ok_d, ack_drv_q, ack_drv_d;
  logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [2:0]    err_code_q, err_code_d;

  logic          rx_s, smp, wrap, destuff, stuff_bit, crc_nxt, abort;
  logic [2:0]    code;
  logic [14:0]   crc_upd;
  logic [3:0]    dlc_full, len_w;

  assign rx_s      = sync2_q;
  assign smp       = tick_16x && (cnt_q == CW'(SAMPLE_POINT));
  assign wrap      = tick_16x && (cnt_q == CW'(OVS_FACTOR - 1));
  assign destuff   = (state_q >= S_SOF) && (state_q <= S_CRC);
  assign stuff_bit = destuff && (run_q == 3'd5);
  assign crc_nxt   = rx_s ^ crc_q[14];
  assign crc_upd   = {crc_q[13:0], 1'b0} ^ (crc_nxt ? POLY : 15'd0);
  assign dlc_full  = {dlc_sh_q[2:0], rx_s};
  assign len_w     = rtr_sh_q ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);

  always_comb begin
    cnt_d = cnt_q;   state_d = state_q;   idle_d = idle_q;   bcnt_d = bcnt_q;
    run_d = run_q;   last_d = last_q;     crc_d = crc_q;     rcrc_d = rcrc_q;
    id_sh_d = id_sh_q;   rtr_sh_d = rtr_sh_q;   dlc_sh_d = dlc_sh_q;
    data_sh_d = data_sh_q;   len_d = len_q;
    rx_id_d = rx_id_q;   rx_rtr_d = rx_rtr_q;   rx_dlc_d = rx_dlc_q;   rx_data_d = rx_data_q;
    ack_ok_d = ack_ok_q;   ack_drv_d = ack_drv_q;   err_code_d = err_code_q;
    rx_valid_d = 1'b0;   rx_err_d = 1'b0;   abort = 1'b0;   code = 3'd0;

    if (tick_16x) cnt_d = (cnt_q == CW'(OVS_FACTOR - 1)) ? '0 : cnt_q + 1'b1;
    // ACK drive spans exactly one bit time: counter wrap into ACK to wrap into ACK_DEL
    if (wrap && state_q == S_ACK)  ack_drv_d = ack_ok_q;
    if (wrap && state_q == S_ADEL) ack_drv_d = 1'b0;

    case (state_q)
      S_WAIT: if (smp) begin
        if (!rx_s) idle_d = '0;
        else if (idle_q == IW'(IDLE_BITS - 1)) begin idle_d = '0; state_d = S_IDLE; end
        else idle_d = idle_q + 1'b1;
      end
      S_IDLE: if (tick_16x && !rx_s) begin
        cnt_d = CW'(1);  state_d = S_SOF;  run_d = 3'd0;  last_d = 1'b0;
        crc_d = '0;  bcnt_d = '0;  data_sh_d = '0;  ack_ok_d = 1'b0;
      end
      default: if (smp) begin
        if (stuff_bit) begin
          if (rx_s == last_q) begin abort = 1'b1; code = 3'd1; end
          else begin run_d = 3'd1; last_d = rx_s; end
        end else begin
          if (destuff) begin
            run_d  = (rx_s == last_q) ? run_q + 1'b1 : 3'd1;
            last_d = rx_s;
          end
          if (state_q <= S_DATA) crc_d = crc_upd;
          case (state_q)
            S_SOF:  state_d = rx_s ? S_IDLE : S_ID;
            S_ID: begin
              id_sh_d = {id_sh_q[9:0], rx_s};
              bcnt_d  = bcnt_q + 1'b1;
              if (bcnt_q == 6'd10) begin bcnt_d = '0; state_d = S_RTR; end
            end
            S_RTR: begin rtr_sh_d = rx_s; state_d = S_IDE; end
            S_IDE: if (rx_s) begin abort = 1'b1; code = 3'd4; end
                   else state_d = S_R0;
            S_R0:  state_d = S_DLC;
            S_DLC: begin
              dlc_sh_d = dlc_full;
              bcnt_d   = bcnt_q + 1'b1;
              if (bcnt_q == 6'd3) begin
                bcnt_d  = '0;
                len_d   = len_w;
                state_d = (len_w == 4'd0) ? S_CRC : S_DATA;
              end
            end
            S_DATA: begin
              // byte N lands in [8N+7:8N], first received bit is the byte MSB
              data_sh_d[{bcnt_q[5:3], ~bcnt_q[2:0]}] = rx_s;
              bcnt_d = bcnt_q + 1'b1;
              if ({1'b0, bcnt_q} == {len_q, 3'b000} - 7'd1) begin bcnt_d = '0; state_d = S_CRC; end
            end
            S_CRC: begin
              rcrc_d = {rcrc_q[13:0], rx_s};
              bcnt_d = bcnt_q + 1'b1;
              if (bcnt_q == 6'd14) begin bcnt_d = '0; state_d = S_CDEL; end
            end
            S_CDEL:
              if (!rx_s)                begin abort = 1'b1; code = 3'd2; end
              else if (rcrc_q != crc_q) begin abort = 1'b1; code = 3'd3; end
              else begin ack_ok_d = ack_en; state_d = S_ACK; end
            S_ACK:  state_d = S_ADEL;
            S_ADEL: if (!rx_s) begin abort = 1'b1; code = 3'd2; end
                    else begin bcnt_d = '0; state_d = S_EOF; end
            S_EOF:
              if (!rx_s) begin abort = 1'b1; code = 3'd2; end
              else if (bcnt_q == 6'd6) begin
                rx_id_d = id_sh_q;  rx_rtr_d = rtr_sh_q;  rx_dlc_d = dlc_sh_q;
                rx_data_d = data_sh_q;  rx_valid_d = 1'b1;  state_d = S_IDLE;
              end else bcnt_d = bcnt_q + 1'b1;
            default: ;
          endcase
        end
      end
    endcase

    if (abort) begin
      state_d = S_WAIT;  idle_d = '0;  rx_err_d = 1'b1;  err_code_d = code;
      ack_ok_d = 1'b0;   ack_drv_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;  sync2_q <= 1'b1;  cnt_q <= '0;  state_q <= S_WAIT;  idle_q <= '0;
      bcnt_q <= '0;  run_q <= '0;  last_q <= 1'b0;  crc_q <= '0;  rcrc_q <= '0;
      id_sh_q <= '0;  rtr_sh_q <= 1'b0;  dlc_sh_q <= '0;  data_sh_q <= '0;  len_q <= '0;
      rx_id_q <= '0;  rx_rtr_q <= 1'b0;  rx_dlc_q <= '0;  rx_data_q <= '0;
      ack_ok_q <= 1'b0;  ack_drv_q <= 1'b0;  rx_valid_q <= 1'b0;  rx_err_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      sync1_q <= can_rx;  sync2_q <= sync1_q;  cnt_q <= cnt_d;  state_q <= state_d;
      idle_q <= idle_d;  bcnt_q <= bcnt_d;  run_q <= run_d;  last_q <= last_d;
      crc_q <= crc_d;  rcrc_q <= rcrc_d;  id_sh_q <= id_sh_d;  rtr_sh_q <= rtr_sh_d;
      dlc_sh_q <= dlc_sh_d;  data_sh_q <= data_sh_d;  len_q <= len_d;
      rx_id_q <= rx_id_d;  rx_rtr_q <= rx_rtr_d;  rx_dlc_q <= rx_dlc_d;  rx_data_q <= rx_data_d;
      ack_ok_q <= ack_ok_d;  ack_drv_q <= ack_drv_d;  rx_valid_q <= rx_valid_d;
      rx_err_q <= rx_err_d;  err_code_q <= err_code_d;
    end
  end

  assign can_tx_ack = ~ack_drv_q;
  assign rx_id      = rx_id_q;
  assign rx_rtr     = rx_rtr_q;
  assign rx_dlc     = rx_dlc_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_err     = rx_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != S_WAIT) && (state_q != S_IDLE);
endmodule

// File: tb/tb_can_rx_frame.sv
// Bench for can_rx_frame: a table of frames driven bit-serially onto a wired-AND
// bus, with a scoreboard matching every rx_valid/rx_err event to its frame.
module tb_can_rx_frame;
  logic clk = 1'b0, rst_n = 1'b0, tick_16x = 1'b0, bus = 1'b1, ack_en = 1'b0;
  logic can_rx, can_tx_ack, rx_rtr, rx_valid, rx_err, busy;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [2:0]  err_code;

  assign can_rx = bus & can_tx_ack;

  can_rx_frame dut (
    .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .can_rx(can_rx), .ack_en(ack_en),
    .can_tx_ack(can_tx_ack), .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick_16x = 1'b1;
      @(negedge clk);
      tick_16x = 1'b0;
    end
  end

  typedef struct {
    logic        is_err;
    logic [2:0]  code;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic        ide;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic        ack_en;
    int          kind;      // 0 clean, 1 first stuff bit forced 0, 2 EOF bit 4 dominant
    logic [14:0] crc_xor;
    logic        exp_err;
    logic [2:0]  exp_code;
    logic [10:0] exp_id;
    logic        exp_rtr;
    logic [3:0]  exp_dlc;
    logic [63:0] exp_data;
    int          exp_ack;   // clk cycles with can_tx_ack low
  } vec_t;

  int   nchecks = 0, nerrs = 0;
  int   ack_clks = 0;
  bit   busy_seen = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  bit   raw[$];
  bit   frm[$];
  int   stuff_pos[$];

  logic [10:0] cur_id = '0;
  logic        cur_rtr = 1'b0;
  logic [3:0]  cur_dlc = '0;
  logic [63:0] cur_data = '0;
  logic [2:0]  cur_code = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!can_tx_ack) ack_clks++;
      if (busy) busy_seen = 1'b1;
      if (rx_valid || rx_err) begin
        if (sb.size() == 0) begin
          nchecks++;
          nerrs++;
          $display("FAIL unexpected_event: rx_valid=%0b rx_err=%0b, expected no event", rx_valid, rx_err);
        end else begin
          mon_e = sb.pop_front();
          chk("ev_rx_err", rx_err, mon_e.is_err);
          chk("ev_rx_valid", rx_valid, !mon_e.is_err);
          if (mon_e.is_err) chk("ev_err_code", err_code, mon_e.code);
          else begin
            chk("ev_rx_id", rx_id, mon_e.id);
            chk("ev_rx_rtr", rx_rtr, mon_e.rtr);
            chk("ev_rx_dlc", rx_dlc, mon_e.dlc);
            chk("ev_rx_data", rx_data, mon_e.data);
          end
        end
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!tick_16x) @(posedge clk);
  endtask

  task automatic drive_bit(input bit b);
    bus = b;
    for (int t = 0; t < 16; t++) wait_tick();
    @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frm();
    foreach (frm[k]) drive_bit(frm[k]);
  endtask

  // Unstuffed SOF..CRC, then stuffing over that span, then fixed-form tail.
  task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                             input logic [3:0] dlc, input logic [63:0] data,
                             input logic [14:0] crc_xor);
    logic [14:0] crc;
    int nb, run;
    bit last, nxt;
    raw.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int b = 0; b < nb; b++)
      for (int i = 7; i >= 0; i--) raw.push_back(data[8*b + i]);
    crc = '0;
    foreach (raw[k]) begin
      nxt = raw[k] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    crc = crc ^ crc_xor;
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    frm.delete();
    stuff_pos.delete();
    run = 0;
    last = 1'b0;
    foreach (raw[k]) begin
      frm.push_back(raw[k]);
      if (raw[k] == last) run++;
      else begin run = 1; last = raw[k]; end
      if (run == 5 && k != raw.size() - 1) begin
        stuff_pos.push_back(frm.size());
        frm.push_back(!last);
        run = 1;
        last = !last;
      end
    end
    for (int i = 0; i < 10; i++) frm.push_back(1'b1);
  endtask

  task automatic drain(input string name);
    for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
    chk(name, sb.size(), 0);
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_rx_id"}, rx_id, cur_id);
    chk({tag, "_rx_rtr"}, rx_rtr, cur_rtr);
    chk({tag, "_rx_dlc"}, rx_dlc, cur_dlc);
    chk({tag, "_rx_data"}, rx_data, cur_data);
    chk({tag, "_err_code"}, err_code, cur_code);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_can_tx_ack"}, can_tx_ack, 1'b1);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    exp_t e;
    vt[0] = '{11'h123, 1'b0, 1'b0, 4'd2,  64'h55AA,             1'b1, 0, 15'h0,    1'b0, 3'd0, 11'h123, 1'b0, 4'd2,  64'h55AA,             64};
    vt[1] = '{11'h000, 1'b0, 1'b0, 4'd0,  64'h0,                1'b1, 1, 15'h0,    1'b1, 3'd1, 11'h0,   1'b0, 4'd0,  64'h0,                0};
    vt[2] = '{11'h123, 1'b0, 1'b0, 4'd2,  64'h55AA,             1'b1, 0, 15'h0010, 1'b1, 3'd3, 11'h0,   1'b0, 4'd0,  64'h0,                0};
    vt[3] = '{11'h123, 1'b0, 1'b0, 4'd2,  64'h55AA,             1'b1, 2, 15'h0,    1'b1, 3'd2, 11'h0,   1'b0, 4'd0,  64'h0,                64};
    vt[4] = '{11'h7FF, 1'b1, 1'b0, 4'd8,  64'h0,                1'b1, 0, 15'h0,    1'b0, 3'd0, 11'h7FF, 1'b1, 4'd8,  64'h0,                64};
    vt[5] = '{11'h321, 1'b0, 1'b1, 4'd1,  64'h77,               1'b1, 0, 15'h0,    1'b1, 3'd4, 11'h0,   1'b0, 4'd0,  64'h0,                0};
    vt[6] = '{11'h555, 1'b0, 1'b0, 4'd4,  64'h0123456789ABCDEF, 1'b0, 0, 15'h0,    1'b0, 3'd0, 11'h555, 1'b0, 4'd4,  64'h89ABCDEF,         0};
    vt[7] = '{11'h0F0, 1'b0, 1'b0, 4'd12, 64'hFFFF0000FFFF0000, 1'b1, 0, 15'h0,    1'b0, 3'd0, 11'h0F0, 1'b0, 4'd12, 64'hFFFF0000FFFF0000, 64};
    vt[8] = '{11'h001, 1'b0, 1'b0, 4'd3,  64'hFFFFFFFFFF000000, 1'b1, 0, 15'h0,    1'b0, 3'd0, 11'h001, 1'b0, 4'd3,  64'h0,                64};

    repeat (4) @(negedge clk);
    check_held("reset");
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_err", rx_err, 1'b0);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      ack_en = vt[v].ack_en;
      build_frame(vt[v].id, vt[v].rtr, vt[v].ide, vt[v].dlc, vt[v].data, vt[v].crc_xor);
      if (vt[v].kind == 1 && stuff_pos.size() > 0) frm[stuff_pos[0]] = 1'b0;
      if (vt[v].kind == 2) frm[frm.size() - 4] = 1'b0;
      idle_bits(12);
      e = '{vt[v].exp_err, vt[v].exp_code, vt[v].exp_id, vt[v].exp_rtr, vt[v].exp_dlc, vt[v].exp_data};
      sb.push_back(e);
      ack_clks = 0;
      send_frm();
      drain($sformatf("v%0d_event", v));
      chk($sformatf("v%0d_ack_clks", v), ack_clks, vt[v].exp_ack);
      if (vt[v].exp_err) cur_code = vt[v].exp_code;
      else begin
        cur_id = vt[v].exp_id;  cur_rtr = vt[v].exp_rtr;
        cur_dlc = vt[v].exp_dlc;  cur_data = vt[v].exp_data;
      end
      check_held($sformatf("v%0d", v));
    end

    // SOF glitch: dominant for a few ticks only, then a frame straight from idle
    ack_en = 1'b1;
    idle_bits(12);
    busy_seen = 1'b0;
    bus = 1'b0;
    for (int t = 0; t < 4; t++) wait_tick();
    @(negedge clk);
    bus = 1'b1;
    for (int t = 0; t < 16; t++) wait_tick();
    @(negedge clk);
    chk("glitch_busy_seen", busy_seen, 1'b1);
    check_held("glitch");
    build_frame(11'h2A5, 1'b0, 1'b0, 4'd1, 64'h3C, 15'h0);
    sb.push_back('{1'b0, 3'd0, 11'h2A5, 1'b0, 4'd1, 64'h3C});
    send_frm();
    drain("glitch_frame_event");
    cur_id = 11'h2A5;  cur_rtr = 1'b0;  cur_dlc = 4'd1;  cur_data = 64'h3C;

    // Reset pulse in the middle of a data byte
    build_frame(11'h123, 1'b0, 1'b0, 4'd2, 64'h55AA, 15'h0);
    idle_bits(12);
    for (int k = 0; k < 25; k++) drive_bit(frm[k]);
    bus = frm[25];
    for (int t = 0; t < 8; t++) wait_tick();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_id = '0;  cur_rtr = 1'b0;  cur_dlc = '0;  cur_data = '0;  cur_code = '0;
    check_held("midrst");
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_rx_err", rx_err, 1'b0);
    idle_bits(5);
    busy_seen = 1'b0;
    send_frm();
    chk("midrst_ignored_busy", busy_seen, 1'b0);
    check_held("midrst_ignored");
    idle_bits(12);
    sb.push_back('{1'b0, 3'd0, 11'h123, 1'b0, 4'd2, 64'h55AA});
    ack_clks = 0;
    send_frm();
    drain("midrst_frame_event");
    chk("midrst_ack_clks", ack_clks, 64);
    cur_id = 11'h123;  cur_dlc = 4'd2;  cur_data = 64'h55AA;
    check_held("final");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
